// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit counter debouncer for the board switches,
// with a sticky change flag/mask that software clears with a one-cycle ack.
module switch_debouncer #(
  parameter int unsigned WIDTH         = 18,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [0:WIDTH-1] raw_switches,
  output logic [0:WIDTH-1] switches,
  output logic             changed,
  output logic [0:WIDTH-1] change_mask,
  input  logic             ack
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES - 1);

  logic [0:WIDTH-1] sync1;
  logic [0:WIDTH-1] sync2;
  logic [0:WIDTH-1] sw_next;
  logic [0:WIDTH-1] toggle;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];

  // A counter only advances while its bit disagrees; any match restarts it,
  // and it never passes LIMIT because reaching LIMIT flips the output.
  always_comb begin
    sw_next = switches;
    toggle  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != switches[i]) begin
        if (cnt[i] >= LIMIT) begin
          sw_next[i] = sync2[i];
          toggle[i]  = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1       <= '0;
      sync2       <= '0;
      switches    <= '0;
      cnt         <= '{default: '0};
      changed     <= 1'b0;
      change_mask <= '0;
    end else begin
      sync1    <= raw_switches;
      sync2    <= sync1;
      switches <= sw_next;
      cnt      <= cnt_next;
      // ack clears old history but keeps a toggle landing on the same edge
      if (ack) begin
        change_mask <= toggle;
        changed     <= |toggle;
      end else begin
        change_mask <= change_mask | toggle;
        changed     <= changed | (|toggle);
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer against a run-length
// reference model of the synchronise/debounce/handshake rules.
module tb_switch_debouncer;

  localparam int W = 18;
  localparam int S = 4;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [0:W-1] raw_switches = '0;
  logic [0:W-1] switches;
  logic         changed;
  logic [0:W-1] change_mask;
  logic         ack = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [0:W-1] pipe[$];
  logic [0:W-1] m_sw;
  logic         m_changed;
  logic [0:W-1] m_mask;
  int           run [W];

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S), .CNT_W(16)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .raw_switches (raw_switches),
    .switches     (switches),
    .changed      (changed),
    .change_mask  (change_mask),
    .ack          (ack)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    pipe = '{'0, '0};
    m_sw = '0;
    m_changed = 1'b0;
    m_mask = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  // A bit flips once it has disagreed with the output for S consecutive
  // edges, where the value seen is the raw level from two edges earlier.
  task automatic model_edge();
    logic [0:W-1] seen;
    logic [0:W-1] tg;
    seen = pipe[0];
    tg = '0;
    for (int i = 0; i < W; i++) begin
      if (seen[i] != m_sw[i]) begin
        run[i] = run[i] + 1;
        if (run[i] == S) begin
          m_sw[i] = seen[i];
          run[i] = 0;
          tg[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
    end
    void'(pipe.pop_front());
    pipe.push_back(raw_switches);
    if (ack) begin
      m_mask = tg;
      m_changed = |tg;
    end else begin
      m_mask = m_mask | tg;
      m_changed = m_changed | (|tg);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (resetn) model_edge();
    #1;
  endtask

  task automatic test_reset();
    raw_switches = 18'h3FFFF;
    resetn = 1'b0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (switches !== 18'h0 || changed !== 1'b0 || change_mask !== 18'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: switches=%h changed=%b mask=%h, required 0/0/0",
                 c, switches, changed, change_mask);
      end
    end
    raw_switches = '0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_clean_toggle();
    raw_switches = 18'h20000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (switches[0] !== (e >= 6)) begin
        errors++;
        $display("FAIL toggle_latency edge %0d: switches[0]=%b required %b", e, switches[0], e >= 6);
      end
    end
    checks++;
    if (changed !== 1'b1 || change_mask !== 18'h20000 || switches !== 18'h20000) begin
      errors++;
      $display("FAIL toggle_flags: switches=%h changed=%b mask=%h, required 20000/1/20000",
               switches, changed, change_mask);
    end
  endtask

  task automatic test_glitch();
    raw_switches = 18'h21000;
    for (int e = 0; e < 3; e++) tick();
    raw_switches = 18'h20000;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (switches !== 18'h20000 || change_mask !== 18'h20000) begin
        errors++;
        $display("FAIL glitch edge %0d: switches=%h mask=%h, required 20000/20000",
                 e, switches, change_mask);
      end
    end
  endtask

  task automatic test_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (changed !== 1'b0 || change_mask !== 18'h0 || switches[0] !== 1'b1) begin
      errors++;
      $display("FAIL ack_clear: changed=%b mask=%h sw0=%b, required 0/0/1",
               changed, change_mask, switches[0]);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (changed !== 1'b0 || change_mask !== 18'h0) begin
      errors++;
      $display("FAIL ack_idle: changed=%b mask=%h, required 0/0", changed, change_mask);
    end
  endtask

  task automatic test_back_to_back();
    raw_switches = 18'h00000;
    for (int e = 0; e < 6; e++) tick();
    checks++;
    if (changed !== 1'b1 || change_mask !== 18'h20000 || switches !== 18'h0) begin
      errors++;
      $display("FAIL reflag_bit0: switches=%h changed=%b mask=%h, required 0/1/20000",
               switches, changed, change_mask);
    end
    raw_switches = 18'h00001;
    for (int e = 0; e < 5; e++) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (changed !== 1'b1 || change_mask !== 18'h00001 || switches !== 18'h00001) begin
      errors++;
      $display("FAIL ack_with_toggle: switches=%h changed=%b mask=%h, required 00001/1/00001",
               switches, changed, change_mask);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    raw_switches = 18'h04001;
    for (int e = 0; e < 3; e++) tick();
    #2 resetn = 1'b0;
    model_clear();
    #1;
    checks++;
    if (switches !== 18'h0 || changed !== 1'b0 || change_mask !== 18'h0) begin
      errors++;
      $display("FAIL reset_async: switches=%h changed=%b mask=%h, required 0/0/0",
               switches, changed, change_mask);
    end
    tick();
    tick();
    resetn = 1'b1;
    edges = 0;
    while (switches[3] !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != S + 2) begin
      errors++;
      $display("FAIL reset_mid_latency: edges=%0d required %0d", edges, S + 2);
    end
  endtask

  task automatic test_random();
    int unsigned bit_i;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        bit_i = $urandom_range(0, W - 1);
        raw_switches[bit_i] = ~raw_switches[bit_i];
      end
      ack = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (switches !== m_sw || changed !== m_changed || change_mask !== m_mask) begin
        errors++;
        $display("FAIL random cycle %0d: sw=%h chg=%b mask=%h, required sw=%h chg=%b mask=%h",
                 c, switches, changed, change_mask, m_sw, m_changed, m_mask);
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_toggle();
    test_glitch();
    test_ack();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
